// File: rtl/program_counter.sv
// 16-bit program counter for the minicpu datapath. On each rising clock edge it clears, loads,
// increments or holds, in that order of priority.
`timescale 1ns / 100ps
module program_counter (
  input  logic [15:0] in_i,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic        reset_i,
  output logic [15:0] out_o,
  input  logic        clock_i
);

  logic [15:0] pc_d;
  logic [15:0] pc_q;

  // Reset beats load, and load beats increment. The increment wraps modulo 2^16.
  always_comb begin
    pc_d = pc_q;
    if (reset_i) begin
      pc_d = 16'h0000;
    end else if (load_i) begin
      pc_d = in_i;
    end else if (inc_i) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    pc_q <= pc_d;
  end

  assign out_o = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a table of directed vectors, hand-written corner
// sequences, and random stimulus checked against a behavioural model.
`timescale 1ns / 100ps
module tb_program_counter;

  logic [15:0] in_s;
  logic        inc_s;
  logic        load_s;
  logic        reset_s;
  logic [15:0] out_s;
  logic        clock_s;

  int checks;
  int failures;
  logic [15:0] model;

  program_counter dut (
    .in_i   (in_s),
    .inc_i  (inc_s),
    .load_i (load_s),
    .reset_i(reset_s),
    .out_o  (out_s),
    .clock_i(clock_s)
  );

  initial clock_s = 1'b0;
  always #1 clock_s = ~clock_s;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        inc;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] exp);
    checks++;
    if (out_s !== exp) begin
      failures++;
      $display("FAIL %s: out=%h expected=%h", name, out_s, exp);
    end
  endtask

  // Starts at a falling edge, drives the inputs, crosses one rising edge and returns at the
  // next falling edge. The model follows the priority rules with plain arithmetic.
  task automatic step(input logic rst, input logic ld, input logic inc, input logic [15:0] din);
    reset_s = rst;
    load_s  = ld;
    inc_s   = inc;
    in_s    = din;
    @(posedge clock_s);
    if (rst) model = 16'h0000;
    else if (ld) model = din;
    else if (inc) model = 16'((32'(model) + 1) % 65536);
    @(negedge clock_s);
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    model    = 16'h0000;
    reset_s  = 1'b0;
    load_s   = 1'b0;
    inc_s    = 1'b0;
    in_s     = 16'h0000;

    // Directed vectors with hand-computed expectations.
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000});
    for (int i = 1; i <= 5; i++) vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'(i)});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h5555, 16'h0005});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0006});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0007});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h9999, 16'h1235});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00A0, 16'h00A0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000});

    @(negedge clock_s);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].inc, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset held for several edges with inc high, then a long count.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'h0000);
      check("reset_hold", 16'h0000);
    end
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      check("count", 16'(i));
    end

    // A reset pulse that falls before the next rising edge must have no effect.
    reset_s = 1'b0;
    inc_s   = 1'b1;
    load_s  = 1'b0;
    #0.3 reset_s = 1'b1;
    #0.3 reset_s = 1'b0;
    @(posedge clock_s);
    @(negedge clock_s);
    check("sync_pulse", 16'd51);
    model = 16'd51;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("after_pulse", 16'd52);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        l;
      logic        c;
      logic [15:0] d;
      r = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, l, c, d);
      check("random", model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: out=%h expected=finish", out_s);
    $fatal(1, "timeout");
  end

endmodule
